approx_mul_err_monitor: RTL and testbench
=========================================

# approx_mul_err_monitor

Streaming error-characterisation stage placed directly downstream of the 8x8 approximate multipliers (`prod8` outputs). It accepts operand/product triples over a valid/ready handshake and recomputes the exact product internally. Over a window of 2^N_LOG2 accepted samples it accumulates:

- the sum of error distances (ED),
- the maximum ED,
- the count of erroneous samples.

It reports these results with a one-cycle `done` pulse. It is used on-FPGA to measure mean error distance (MED) and error rate (ER) of each multiplier variant without host post-processing.

## Interface
Parameters:
- `N_LOG2`, default 8: window length is 2^N_LOG2 samples; legal range 1..16.
- `ACC_W`, default 16+N_LOG2: width of `err_sum`; derived, do not override.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a measurement window.
- `in_valid`  in  1  sample present on `a`/`b`/`prod_approx`.
- `in_ready`  out  1  high only in state RUN.
- `a`  in  8  multiplicand fed to the multiplier under test.
- `b`  in  8  multiplier fed to the multiplier under test.
- `prod_approx`  in  16  `prod8` of the multiplier under test.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse when results are final.
- `err_sum`  out  ACC_W  sum of |a*b − prod_approx| over the window.
- `err_max`  out  16  maximum ED in the window.
- `err_cnt`  out  N_LOG2+1  number of samples with ED ≠ 0.
- `err_bias`  out  ACC_W+1  signed sum of (prod_approx − a*b); see Configuration.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: wait for `start`.
  - `start` in IDLE clears `err_sum`, `err_max`, `err_cnt`, `err_bias` and the sample counter, then goes to RUN.
  - RUN: a sample is accepted on any cycle with `in_valid && in_ready`. The sample counter increments per accept.
  - The accept that brings the counter to 2^N_LOG2 moves the FSM to DRAIN.
  - DRAIN lasts exactly 2 cycles, then goes to DONE.
  - DONE lasts 1 cycle (`done`=1), then goes to IDLE.
- Datapath is a 2-stage pipeline:
  - Stage 1 registers exact = a*b (16-bit unsigned), ED = |exact − prod_approx| (16-bit), and nz = (ED≠0).
  - Stage 2 performs `err_sum += ED`, `err_max = max(err_max, ED)`, `err_cnt += nz`.
- Arithmetic: all unsigned. The difference is computed at 17 bits before taking the magnitude. `err_sum` cannot overflow, because 2^N_LOG2 × 65535 < 2^ACC_W.
- `start` outside IDLE is ignored (no restart, no clear).
- Results hold their values in IDLE until the next accepted `start`.
- `in_valid` may drop at any time in RUN. Gaps stall counting and do not time out.
- Inputs are sampled only on the accept cycle. They are don't-care otherwise.

## Timing
- Reset values:
  - state = IDLE;
  - `in_ready`, `busy`, `done` = 0;
  - `err_sum`, `err_max`, `err_cnt`, `err_bias` = 0;
  - pipeline valids = 0.
- `rst` asserted mid-window aborts immediately. No `done` is produced, and partial results are discarded (zeroed).
- `start` at edge k: `in_ready`=1 from cycle k+1.
- A sample accepted in cycle t is visible in the outputs from cycle t+2.
- Last accept in cycle t:
  - `in_ready`=0 from cycle t+1;
  - DRAIN covers cycles t+1 and t+2;
  - `done`=1 in cycle t+3 only;
  - `busy` falls in cycle t+3.
- Outputs are final and stable in the cycle where `done`=1.
- Minimum window duration is 2^N_LOG2 + 4 cycles from `start` to `done`, with `in_valid` held high.

## Configuration
- `ERR_BIAS_EN` defined:
  - Stage 1 also registers the signed 17-bit value (prod_approx − exact).
  - Stage 2 accumulates it into `err_bias` (two's complement, ACC_W+1 bits) for mean-error/bias measurement.
- `ERR_BIAS_EN` undefined: the bias datapath is not compiled and `err_bias` is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- N_LOG2=8, 256 samples with `prod_approx` = a*b (random a, b) -> `done` once; `err_sum`=0, `err_max`=0, `err_cnt`=0.
- 256 samples with `prod_approx` = a*b − 1 (a*b≥1) -> `err_sum`=256, `err_max`=1, `err_cnt`=256; with `ERR_BIAS_EN`, `err_bias` = −256.
- One sample a=255, b=255, `prod_approx`=0 plus 255 exact samples -> `err_sum`=65025, `err_max`=65025, `err_cnt`=1.
- `in_valid` toggled 1/0 every cycle, `start` re-pulsed during RUN -> still exactly 256 accepts; `done` 3 cycles after the 256th accept; second `start` has no effect.
- `rst` pulsed after 100 accepts -> all outputs 0, FSM IDLE, no `done`; a fresh `start` then completes a normal window.
- Back-to-back windows: `start` in the cycle after `done` -> results cleared and the new window is accepted from the next cycle.

Source files
------------

// File: rtl/approx_mul_err_monitor.sv
// Streaming error monitor for 8x8 approximate multipliers: per window it accumulates the ED sum, the ED max and the error count.
// Optional ERR_BIAS_EN macro adds a signed bias accumulator; without it err_bias is tied to zero.
module approx_mul_err_monitor #(
  parameter int N_LOG2 = 8,
  parameter int ACC_W  = 16 + N_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        a,
  input  logic [7:0]        b,
  input  logic [15:0]       prod_approx,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  err_sum,
  output logic [15:0]       err_max,
  output logic [N_LOG2:0]   err_cnt,
  output logic [ACC_W:0]    err_bias
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int WIN = 1 << N_LOG2;
  localparam logic [N_LOG2:0] LAST = (N_LOG2+1)'(WIN - 1);

  state_t            state_q, state_d;
  logic [N_LOG2:0]   cnt_q;
  logic              drain_q;
  logic              accept, start_ok, last_acc;

  logic [15:0]       exact_w;
  logic [16:0]       diff_w, neg_w;
  logic [15:0]       ed_w;

  logic              s1_valid_q, s1_nz_q;
  logic [15:0]       s1_ed_q;
  logic [ACC_W-1:0]  err_sum_q;
  logic [15:0]       err_max_q;
  logic [N_LOG2:0]   err_cnt_q;

  assign accept   = in_valid && in_ready;
  assign start_ok = start && (state_q == IDLE);
  assign last_acc = accept && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (last_acc) state_d = DRAIN;
      DRAIN:   if (drain_q)  state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == RUN);
    busy     = (state_q == RUN) || (state_q == DRAIN);
    done     = (state_q == DONE);
  end

  // drain_q marks the second DRAIN cycle so the pipeline has fully retired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      if (start_ok)    cnt_q <= '0;
      else if (accept) cnt_q <= cnt_q + 1'b1;
      drain_q <= (state_q == DRAIN) && !drain_q;
    end
  end

  // The difference is taken at 17 bits so its sign gives the magnitude direction.
  assign exact_w = {8'd0, a} * {8'd0, b};
  assign diff_w  = {1'b0, prod_approx} - {1'b0, exact_w};
  assign neg_w   = -diff_w;
  assign ed_w    = diff_w[16] ? neg_w[15:0] : diff_w[15:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_ed_q    <= '0;
      s1_nz_q    <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_ed_q <= ed_w;
        s1_nz_q <= |ed_w;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sum_q <= '0;
      err_max_q <= '0;
      err_cnt_q <= '0;
    end else if (start_ok) begin
      err_sum_q <= '0;
      err_max_q <= '0;
      err_cnt_q <= '0;
    end else if (s1_valid_q) begin
      err_sum_q <= err_sum_q + ACC_W'(s1_ed_q);
      if (s1_ed_q > err_max_q) err_max_q <= s1_ed_q;
      err_cnt_q <= err_cnt_q + (N_LOG2+1)'(s1_nz_q);
    end
  end

  assign err_sum = err_sum_q;
  assign err_max = err_max_q;
  assign err_cnt = err_cnt_q;

`ifdef ERR_BIAS_EN
  logic [16:0]  s1_diff_q;
  logic [ACC_W:0] err_bias_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_diff_q  <= '0;
      err_bias_q <= '0;
    end else begin
      if (accept) s1_diff_q <= diff_w;
      if (start_ok)        err_bias_q <= '0;
      else if (s1_valid_q) err_bias_q <= err_bias_q + {{(ACC_W-16){s1_diff_q[16]}}, s1_diff_q};
    end
  end

  assign err_bias = err_bias_q;
`else
  assign err_bias = '0;
`endif

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Scoreboard bench for approx_mul_err_monitor: stimulus pushes hand-computed window results,
// a monitor pops and compares them on every done pulse.
module tb_approx_mul_err_monitor;
  localparam int N_LOG2 = 8;
  localparam int ACC_W  = 16 + N_LOG2;
  localparam int WIN    = 1 << N_LOG2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        a = '0;
  logic [7:0]        b = '0;
  logic [15:0]       prod_approx = '0;
  logic              in_ready, busy, done;
  logic [ACC_W-1:0]  err_sum;
  logic [15:0]       err_max;
  logic [N_LOG2:0]   err_cnt;
  logic [ACC_W:0]    err_bias;

  approx_mul_err_monitor #(.N_LOG2(N_LOG2)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .prod_approx(prod_approx), .busy(busy), .done(done),
    .err_sum(err_sum), .err_max(err_max), .err_cnt(err_cnt), .err_bias(err_bias)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint sum;
    longint mx;
    longint cnt;
    longint bias;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int accepts = 0;
  int done_seen = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_exp(input longint s, input longint m, input longint c, input longint bias);
    exp_t e;
    e.sum = s;
    e.mx  = m;
    e.cnt = c;
`ifdef ERR_BIAS_EN
    e.bias = bias;
`else
    e.bias = 0;
`endif
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_seen++;
        if (sb.size() == 0) begin
          chk("unexpected_done", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("window %0d: sum=%0d max=%0d cnt=%0d bias=%0d latency=%0d",
                   done_seen, err_sum, err_max, err_cnt, $signed(err_bias), cyc - last_acc_cyc);
          chk("err_sum", longint'(err_sum), e.sum);
          chk("err_max", longint'(err_max), e.mx);
          chk("err_cnt", longint'(err_cnt), e.cnt);
          chk("err_bias", longint'($signed(err_bias)), e.bias);
          chk("done_latency", cyc - last_acc_cyc, 3);
          chk("busy_at_done", longint'(busy), 0);
          chk("in_ready_at_done", longint'(in_ready), 0);
        end
      end
      if (done && done_prev) chk("done_one_cycle", longint'(done_prev), 0);
      done_prev = done;
    end else begin
      done_prev = 1'b0;
    end
  end

  function automatic logic [15:0] prod_for(input int mode, input int i, input logic [7:0] aa, input logic [7:0] bb);
    logic [15:0] p;
    p = {8'd0, aa} * {8'd0, bb};
    case (mode)
      1: p = p - 16'd1;
      2: if (i == 0) p = 16'd0;
      3: p = p + 16'd3;
      4: if (i % 2 == 1) p = p + 16'd5;
      5: if (i == 0) p = 16'd1000;
      default: ;
    endcase
    return p;
  endfunction

  task automatic pulse_start(input bit push, input longint s, input longint m, input longint c, input longint bias);
    @(negedge clk);
    start = 1'b1;
    if (push) push_exp(s, m, c, bias);
    @(negedge clk);
    start = 1'b0;
    chk("in_ready_after_start", longint'(in_ready), 1);
    chk("cleared_on_start", longint'(err_sum), 0);
  endtask

  task automatic send(input int mode, input int n, input bit toggle, input int restart_at);
    int guard = 0;
    bit ph = 1'b0;
    bit restarted = 1'b0;
    logic [7:0] aa, bb;
    accepts = 0;
    while (accepts < n && guard < 4000) begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      if (toggle && ph) begin
        in_valid = 1'b0;
      end else begin
        aa = 8'($urandom_range(1, (mode <= 1) ? 255 : 200));
        bb = 8'($urandom_range(1, (mode <= 1) ? 255 : 200));
        if (mode == 2 && accepts == 0) begin aa = 8'd255; bb = 8'd255; end
        if (mode == 5 && accepts == 0) begin aa = 8'd16;  bb = 8'd16;  end
        a = aa;
        b = bb;
        prod_approx = prod_for(mode, accepts, aa, bb);
        in_valid = 1'b1;
        if (in_ready) begin
          accepts++;
          last_acc_cyc = cyc;
        end
      end
      if (restart_at >= 0 && accepts == restart_at && !restarted) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      ph = ~ph;
    end
    if (guard >= 4000) chk("accept_timeout", accepts, n);
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    if (n == WIN) begin
      chk("in_ready_after_last", longint'(in_ready), 0);
      chk("busy_in_drain", longint'(busy), 1);
    end
  endtask

  task automatic wait_done();
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!done && g < 100);
    if (g >= 100) chk("done_timeout", g, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_err_sum", longint'(err_sum), 0);
    chk("rst_err_max", longint'(err_max), 0);
    chk("rst_err_cnt", longint'(err_cnt), 0);
    chk("rst_err_bias", longint'(err_bias), 0);

    // exact products
    pulse_start(1'b1, 0, 0, 0, 0);
    send(0, WIN, 1'b0, -1);
    wait_done();

    // every product one low
    pulse_start(1'b1, 256, 1, 256, -256);
    send(1, WIN, 1'b0, -1);
    wait_done();

    // one worst-case sample then exact
    pulse_start(1'b1, 65025, 65025, 1, -65025);
    send(2, WIN, 1'b0, -1);
    wait_done();
    repeat (4) @(negedge clk);
    chk("hold_err_sum_idle", longint'(err_sum), 65025);
    chk("idle_busy", longint'(busy), 0);

    // gapped input with a stray start during RUN
    pulse_start(1'b1, 768, 3, 256, 768);
    send(3, WIN, 1'b1, 50);
    wait_done();

    // abort after 100 accepts
    pulse_start(1'b0, 0, 0, 0, 0);
    send(1, 100, 1'b0, -1);
    chk("partial_sum_before_abort", longint'(err_sum), 99);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_err_sum", longint'(err_sum), 0);
    chk("abort_err_max", longint'(err_max), 0);
    chk("abort_err_cnt", longint'(err_cnt), 0);
    chk("abort_in_ready", longint'(in_ready), 0);
    chk("abort_busy", longint'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_idle_busy", longint'(busy), 0);

    // fresh window, every other sample off by five
    pulse_start(1'b1, 640, 5, 128, 640);
    send(4, WIN, 1'b0, -1);
    wait_done();

    // back-to-back: start in the cycle right after done
    @(negedge clk);
    start = 1'b1;
    push_exp(744, 744, 1, 744);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_in_ready", longint'(in_ready), 1);
    chk("b2b_cleared", longint'(err_sum), 0);
    send(5, WIN, 1'b0, -1);
    wait_done();

    repeat (3) @(negedge clk);
    chk("windows_completed", done_seen, 6);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
